fifo_burst_wr: RTL and testbench

Parametrised FIFO write controller: the next generation of the single-shot byte writer in the UART FIFO path. It is armed by `start` and waits for the read side to report `almost_empty`, synchronised into the write domain. It then waits a programmable settle time and writes a burst of `BURST_LEN` words into the FIFO IP. Words come either from an upstream valid/ready stream (e.g. UART RX) or from an internal incrementing pattern. Writing pauses on `almost_full` and resumes when it clears, and the block reports completion, word count and busy.

---
 rtl/fifo_burst_wr.sv | 127 ++++++++++++
 tb/tb_fifo_burst_wr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_wr.sv
// rtl/fifo_burst_wr.sv - armed burst writer feeding a FIFO from a stream or an incrementing pattern
module fifo_burst_wr #(
   parameter int DATA_W      = 8,
   parameter int BURST_LEN   = 256,
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic              almost_empty,
   input  logic              almost_full,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wr_data,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic              busy,
   output logic              fifo_wr_ok
);

   localparam int               DLY_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_EMPTY,
      S_SETTLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic                   mode_q;
   logic [SYNC_STAGES-1:0] ae_sync_q;
   logic [DLY_W-1:0]       dly_q;
   logic [DATA_W-1:0]      pat_q;
   logic [CNT_W-1:0]       wr_cnt_q;
   logic [CNT_W-1:0]       wr_cnt_d;
   logic                   wr_en_q;
   logic [DATA_W-1:0]      wr_data_q;
   logic                   wr_ok_q;
   logic                   in_write;
   logic                   accept;

   // abort masks the handshake in its own cycle so nothing is accepted while cancelling
   assign in_write = (state_q == S_WRITE) && !abort && !almost_full;
   assign accept   = in_write && (mode_q || in_valid);
   assign in_ready = in_write && !mode_q;
   assign wr_cnt_d = wr_cnt_q + 1'b1;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         ae_sync_q <= '0;
      end else begin
         ae_sync_q <= {ae_sync_q[SYNC_STAGES-2:0], almost_empty};
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         dly_q     <= '0;
         pat_q     <= '0;
         wr_cnt_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         wr_ok_q   <= 1'b0;
      end else begin
         wr_en_q <= accept;
         wr_ok_q <= 1'b0;
         if (accept) begin
            wr_data_q <= mode_q ? pat_q : in_data;
            wr_cnt_q  <= wr_cnt_d;
            pat_q     <= pat_q + 1'b1;
         end
         if (abort) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     state_q  <= S_WAIT_EMPTY;
                     mode_q   <= mode;
                     wr_cnt_q <= '0;
                     pat_q    <= '0;
                  end
               end
               S_WAIT_EMPTY: begin
                  if (ae_sync_q[SYNC_STAGES-1]) begin
                     dly_q   <= '0;
                     state_q <= (SETTLE_CYC == 0) ? S_WRITE : S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (dly_q == DLY_LAST) begin
                     state_q <= S_WRITE;
                  end else begin
                     dly_q <= dly_q + 1'b1;
                  end
               end
               S_WRITE: begin
                  if (accept && (wr_cnt_d == CNT_LAST)) begin
                     state_q <= S_DONE;
                     wr_ok_q <= 1'b1;
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign fifo_wr_en   = wr_en_q;
   assign fifo_wr_data = wr_data_q;
   assign wr_cnt       = wr_cnt_q;
   assign fifo_wr_ok   = wr_ok_q;

endmodule

// File: tb/tb_fifo_burst_wr.sv
// tb/tb_fifo_burst_wr.sv - randomized bench for two fifo_burst_wr configurations against a timestamp model
module tb_fifo_burst_wr;

   localparam int N      = 2;
   localparam int CYCLES = 6000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort, mode, ae, af, in_valid;
   logic [7:0] in_data;

   logic       in_ready_a, wr_en_a, busy_a, ok_a;
   logic [3:0] data_a;
   logic [7:0] cnt_a;
   logic       in_ready_b, wr_en_b, busy_b, ok_b;
   logic [7:0] data_b;
   logic [7:0] cnt_b;

   fifo_burst_wr #(
      .DATA_W(4), .BURST_LEN(20), .CNT_W(8), .SETTLE_CYC(5), .SYNC_STAGES(2)
   ) u_dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .almost_empty(ae), .almost_full(af), .in_valid(in_valid), .in_data(in_data[3:0]),
      .in_ready(in_ready_a), .fifo_wr_en(wr_en_a), .fifo_wr_data(data_a),
      .wr_cnt(cnt_a), .busy(busy_a), .fifo_wr_ok(ok_a)
   );

   fifo_burst_wr #(
      .DATA_W(8), .BURST_LEN(6), .CNT_W(8), .SETTLE_CYC(0), .SYNC_STAGES(3)
   ) u_dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .almost_empty(ae), .almost_full(af), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_b), .fifo_wr_en(wr_en_b), .fifo_wr_data(data_b),
      .wr_cnt(cnt_b), .busy(busy_b), .fifo_wr_ok(ok_b)
   );

   int p_burst [N] = '{20, 6};
   int p_settle[N] = '{5, 0};
   int p_sync  [N] = '{2, 3};
   int p_mask  [N] = '{15, 255};

   // model: a burst is described by when writing may begin and when it finished
   bit m_busy   [N];
   bit m_mode   [N];
   int m_wr_from[N];
   int m_done_at[N];
   int m_cnt    [N];
   int m_pat    [N];
   bit e_wr_en  [N];
   int e_data   [N];
   bit e_ok     [N];
   bit ae_hist  [CYCLES];
   int last_rst;

   int n_pass   = 0;
   int n_checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic bit ae_seen(input int i, input int c);
      int src;
      src = c - p_sync[i];
      return (src >= 0 && last_rst < src) ? ae_hist[src] : 1'b0;
   endfunction

   task automatic model_clear(input int i);
      m_busy[i]    = 1'b0;
      m_mode[i]    = 1'b0;
      m_wr_from[i] = -1;
      m_done_at[i] = -1;
      m_cnt[i]     = 0;
      m_pat[i]     = 0;
      e_wr_en[i]   = 1'b0;
      e_data[i]    = 0;
      e_ok[i]      = 1'b0;
   endtask

   initial begin
      int af_run;
      bit can_write;
      bit acc;
      logic [31:0] g_en, g_data, g_cnt, g_busy, g_ok, g_rdy;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
      ae = 1'b0; af = 1'b0; in_valid = 1'b0; in_data = '0;
      af_run = 0;
      last_rst = -1;
      for (int i = 0; i < N; i++) model_clear(i);
      repeat (2) @(posedge clk);
      #1;

      for (int c = 0; c < CYCLES; c++) begin
         for (int i = 0; i < N; i++) begin
            g_en   = (i == 0) ? 32'(wr_en_a) : 32'(wr_en_b);
            g_data = (i == 0) ? 32'(data_a)  : 32'(data_b);
            g_cnt  = (i == 0) ? 32'(cnt_a)   : 32'(cnt_b);
            g_busy = (i == 0) ? 32'(busy_a)  : 32'(busy_b);
            g_ok   = (i == 0) ? 32'(ok_a)    : 32'(ok_b);
            check_eq($sformatf("dut%0d.fifo_wr_en@%0d", i, c), g_en, 32'(e_wr_en[i]));
            check_eq($sformatf("dut%0d.fifo_wr_data@%0d", i, c), g_data, 32'(e_data[i]));
            check_eq($sformatf("dut%0d.wr_cnt@%0d", i, c), g_cnt, 32'(m_cnt[i]));
            check_eq($sformatf("dut%0d.busy@%0d", i, c), g_busy, 32'(m_busy[i]));
            check_eq($sformatf("dut%0d.fifo_wr_ok@%0d", i, c), g_ok, 32'(e_ok[i]));
         end

         rst_n    = (c == 0) ? 1'b0 : ($urandom_range(0, 699) != 0);
         start    = ($urandom_range(0, 5) == 0);
         abort    = ($urandom_range(0, 119) == 0);
         mode     = 1'($urandom_range(0, 1));
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = 8'($urandom);
         if ($urandom_range(0, 9) == 0) ae = ~ae;
         if (af_run > 0) af_run--;
         else if ($urandom_range(0, 24) == 0) af_run = $urandom_range(1, 6);
         af = (af_run > 0);
         #1;
         ae_hist[c] = ae;

         for (int i = 0; i < N; i++) begin
            can_write = m_busy[i] && m_done_at[i] < 0 && m_wr_from[i] >= 0 && c >= m_wr_from[i];
            g_rdy = (i == 0) ? 32'(in_ready_a) : 32'(in_ready_b);
            check_eq($sformatf("dut%0d.in_ready@%0d", i, c), g_rdy,
                     32'(can_write && !m_mode[i] && !af && !abort));

            if (!rst_n) begin
               model_clear(i);
            end else begin
               acc = can_write && !abort && !af && (m_mode[i] || in_valid);
               e_wr_en[i] = acc;
               e_ok[i]    = 1'b0;
               if (acc) begin
                  e_data[i] = m_mode[i] ? m_pat[i] : (int'(in_data) & p_mask[i]);
                  m_pat[i]  = (m_pat[i] + 1) & p_mask[i];
                  m_cnt[i]++;
               end
               if (m_busy[i] && abort) begin
                  m_busy[i] = 1'b0;
               end else if (m_busy[i]) begin
                  if (m_done_at[i] == c) begin
                     m_busy[i] = 1'b0;
                  end else if (acc && m_cnt[i] == p_burst[i]) begin
                     m_done_at[i] = c + 1;
                     e_ok[i]      = 1'b1;
                  end else if (m_wr_from[i] < 0 && ae_seen(i, c)) begin
                     m_wr_from[i] = c + 1 + p_settle[i];
                  end
               end else if (start && !abort) begin
                  m_busy[i]    = 1'b1;
                  m_mode[i]    = mode;
                  m_cnt[i]     = 0;
                  m_pat[i]     = 0;
                  m_wr_from[i] = -1;
                  m_done_at[i] = -1;
               end
            end
         end
         if (!rst_n) last_rst = c;

         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
